// File: rtl/lc_trans_guard_pkg.sv
// Shared types and error codes for the life-cycle transition guard.
package lc_trans_guard_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_COMMIT = 3'd2,
        ST_RESP   = 3'd3,
        ST_LOCK   = 3'd4
    } lc_fsm_e;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_REDUN   = 3'd1;
    localparam logic [2:0] ERR_INVALID = 3'd2;
    localparam logic [2:0] ERR_SELF    = 3'd3;
    localparam logic [2:0] ERR_ILLEGAL = 3'd4;

    typedef enum logic [2:0] {
        RAW            = 3'd0,
        TEST_UNLOCKED0 = 3'd1,
        TEST_LOCKED0   = 3'd2,
        RMA            = 3'd3,
        INVALID        = 3'd7
    } dec_lc_state_e;

endpackage

// File: rtl/lc_trans_guard_if.sv
// Transition command/response handshake between requester and guard.
interface lc_trans_guard_if #(
    parameter int STATE_W = 3,
    parameter int NUM_REP = 2
);
    import lc_trans_guard_pkg::*;

    logic                       req_valid;
    logic [NUM_REP*STATE_W-1:0] req_target;
    logic                       req_ready;
    logic                       rsp_valid;
    logic                       rsp_ok;
    logic [2:0]                 rsp_err;

    modport master (
        output req_valid, req_target,
        input  req_ready, rsp_valid, rsp_ok, rsp_err
    );

    modport slave (
        input  req_valid, req_target,
        output req_ready, rsp_valid, rsp_ok, rsp_err
    );

endinterface

// File: rtl/lc_hist_buf.sv
// History of committed targets; entry 0 holds the newest, the oldest drops off on push.
module lc_hist_buf
    import lc_trans_guard_pkg::*;
#(
    parameter int HIST_DEPTH  = 4,
    parameter int STATE_W     = 3,
    parameter int RESET_STATE = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic [STATE_W-1:0]            din,
    output logic [HIST_DEPTH*STATE_W-1:0] hist
);

    logic [STATE_W-1:0] entry [HIST_DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < HIST_DEPTH; i++) begin
                entry[i] <= STATE_W'(RESET_STATE);
            end
        end else if (push) begin
            entry[0] <= din;
            for (int i = 1; i < HIST_DEPTH; i++) begin
                entry[i] <= entry[i-1];
            end
        end
    end

    for (genvar g = 0; g < HIST_DEPTH; g++) begin : g_out
        assign hist[g*STATE_W +: STATE_W] = entry[g];
    end

endmodule

// File: rtl/lc_trans_guard.sv
// Life-cycle transition guard: checks redundant targets against a legality matrix,
// commits accepted transitions and locks out after repeated rejections.
//
//   state  | meaning
//   IDLE   | ready for a request
//   CHECK  | evaluate captured target, latch error code
//   COMMIT | update cur_state and history
//   RESP   | one-cycle response pulse
//   LOCK   | timed lockout after ERR_THRESH rejections
module lc_trans_guard
    import lc_trans_guard_pkg::*;
#(
    parameter int STATE_W     = 3,
    parameter int NUM_REP     = 2,
    parameter int NUM_STATES  = 8,
    parameter int RESET_STATE = 0,
    parameter int HIST_DEPTH  = 4,
    parameter int ERR_THRESH  = 3,
    parameter int LOCK_CYCLES = 16
) (
    input  logic                                clk,
    input  logic                                rst_n,
    lc_trans_guard_if.slave                     bus,
    input  logic [NUM_STATES*NUM_STATES-1:0]    legal_map,
    output logic [STATE_W-1:0]                  cur_state,
    output logic [HIST_DEPTH*STATE_W-1:0]       hist,
    output logic [$clog2(ERR_THRESH+1)-1:0]     err_cnt,
    output logic                                locked,
    output logic                                alert
);

    localparam int CNT_W = $clog2(ERR_THRESH + 1);
    localparam int LCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam int IDX_W = $clog2(NUM_STATES * NUM_STATES);

    lc_fsm_e state, state_nxt;

    logic [NUM_REP*STATE_W-1:0] cap_target;
    logic [STATE_W-1:0]         tgt;
    logic [LCK_W-1:0]           lock_cnt;
    logic [IDX_W-1:0]           map_idx;
    logic [2:0]                 chk_err;
    logic                       redun_ok;
    logic                       rsp_ok_q;
    logic [2:0]                 rsp_err_q;

    assign tgt = cap_target[STATE_W-1:0];

    // Checks are prioritised; later ones only matter once earlier ones pass,
    // so an out-of-range map index for an invalid target is never used.
    always_comb begin
        redun_ok = 1'b1;
        for (int i = 1; i < NUM_REP; i++) begin
            if (cap_target[i*STATE_W +: STATE_W] != tgt) redun_ok = 1'b0;
        end
        map_idx = IDX_W'(cur_state) * IDX_W'(NUM_STATES) + IDX_W'(tgt);
        chk_err = ERR_NONE;
        if (!redun_ok)                          chk_err = ERR_REDUN;
        else if (int'(tgt) >= NUM_STATES - 1)   chk_err = ERR_INVALID;
        else if (tgt == cur_state)              chk_err = ERR_SELF;
        else if (!legal_map[map_idx])           chk_err = ERR_ILLEGAL;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (bus.req_valid) state_nxt = ST_CHECK;
            ST_CHECK:  state_nxt = (chk_err == ERR_NONE) ? ST_COMMIT : ST_RESP;
            ST_COMMIT: state_nxt = ST_RESP;
            ST_RESP:   state_nxt = (err_cnt == CNT_W'(ERR_THRESH)) ? ST_LOCK : ST_IDLE;
            ST_LOCK:   if (lock_cnt == '0) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cap_target <= '0;
            cur_state  <= STATE_W'(RESET_STATE);
            err_cnt    <= '0;
            rsp_ok_q   <= 1'b0;
            rsp_err_q  <= ERR_NONE;
            lock_cnt   <= '0;
            alert      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) cap_target <= bus.req_target;
                end
                ST_CHECK: begin
                    rsp_err_q <= chk_err;
                    rsp_ok_q  <= (chk_err == ERR_NONE);
                    if (chk_err != ERR_NONE && err_cnt != CNT_W'(ERR_THRESH))
                        err_cnt <= err_cnt + 1'b1;
                end
                ST_COMMIT: begin
                    cur_state <= tgt;
                    err_cnt   <= '0;
                end
                ST_RESP: begin
                    if (state_nxt == ST_LOCK) begin
                        lock_cnt <= LCK_W'(LOCK_CYCLES - 1);
                        alert    <= 1'b1;
                    end
                end
                ST_LOCK: begin
                    if (lock_cnt == '0) err_cnt  <= '0;
                    else                lock_cnt <= lock_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    lc_hist_buf #(
        .HIST_DEPTH  (HIST_DEPTH),
        .STATE_W     (STATE_W),
        .RESET_STATE (RESET_STATE)
    ) u_hist (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (state == ST_COMMIT),
        .din   (tgt),
        .hist  (hist)
    );

    assign bus.req_ready = rst_n && (state == ST_IDLE);
    assign bus.rsp_valid = (state == ST_RESP);
    assign bus.rsp_ok    = rsp_ok_q;
    assign bus.rsp_err   = rsp_err_q;
    assign locked        = (state == ST_LOCK);

endmodule

// File: tb/tb_lc_trans_guard.sv
// Scoreboard bench for lc_trans_guard: requests push expected responses, a monitor pops and compares.
module tb_lc_trans_guard;
    import lc_trans_guard_pkg::*;

    localparam int SW = 3;
    localparam int NR = 2;
    localparam int NS = 8;
    localparam int HD = 4;
    localparam int ET = 3;
    localparam int LC = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NS*NS-1:0]  legal_map;
    logic [SW-1:0]     cur_state;
    logic [HD*SW-1:0]  hist;
    logic [1:0]        err_cnt;
    logic              locked;
    logic              alert;

    int cyc = 0;
    int total = 0;
    int bad = 0;

    typedef struct {
        logic             ok;
        logic [2:0]       err;
        logic [SW-1:0]    cur;
        logic [HD*SW-1:0] hst;
        logic [1:0]       ecnt;
        logic             alrt;
        int               lat;
        int               acc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    logic [SW-1:0]    m_cur;
    logic [HD*SW-1:0] m_hist;
    int               m_err;
    logic             m_alert;

    lc_trans_guard_if #(.STATE_W(SW), .NUM_REP(NR)) bus();

    lc_trans_guard #(
        .STATE_W(SW), .NUM_REP(NR), .NUM_STATES(NS), .RESET_STATE(0),
        .HIST_DEPTH(HD), .ERR_THRESH(ET), .LOCK_CYCLES(LC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .legal_map (legal_map),
        .cur_state (cur_state),
        .hist      (hist),
        .err_cnt   (err_cnt),
        .locked    (locked),
        .alert     (alert)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid) begin
            chk("rsp_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("rsp_ok",    bus.rsp_ok,       mon_e.ok);
                chk("rsp_err",   bus.rsp_err,      mon_e.err);
                chk("cur_state", cur_state,        mon_e.cur);
                chk("hist",      hist,             mon_e.hst);
                chk("err_cnt",   err_cnt,          mon_e.ecnt);
                chk("alert",     alert,            mon_e.alrt);
                chk("latency",   cyc - mon_e.acc,  mon_e.lat);
                chk("rsp_lock",  locked,           1'b0);
            end
        end
    end

    task automatic model_reset();
        m_cur   = '0;
        m_hist  = '0;
        m_err   = 0;
        m_alert = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("rst_ready", bus.req_ready, 1'b0);
        rst_n = 1'b1;
        model_reset();
        chk("rst_cur",     cur_state,     0);
        chk("rst_hist",    hist,          0);
        chk("rst_err_cnt", err_cnt,       0);
        chk("rst_rsp_vld", bus.rsp_valid, 0);
        chk("rst_rsp_ok",  bus.rsp_ok,    0);
        chk("rst_rsp_err", bus.rsp_err,   0);
        chk("rst_locked",  locked,        0);
        chk("rst_alert",   alert,         0);
    endtask

    task automatic send(input logic [SW-1:0] c0, input logic [SW-1:0] c1);
        exp_t e;
        int   g;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_target = {c1, c0};
        g = 0;
        while (!bus.req_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk("accept", bus.req_ready, 1'b1);
        if (m_err == ET) begin
            m_err   = 0;
            m_alert = 1'b1;
        end
        if (c1 != c0)                         e.err = ERR_REDUN;
        else if (int'(c0) >= NS - 1)          e.err = ERR_INVALID;
        else if (c0 == m_cur)                 e.err = ERR_SELF;
        else if (!legal_map[int'(m_cur)*NS + int'(c0)]) e.err = ERR_ILLEGAL;
        else                                  e.err = ERR_NONE;
        if (e.err == ERR_NONE) begin
            m_cur  = c0;
            m_hist = {m_hist[HD*SW-SW-1:0], c0};
            m_err  = 0;
            e.lat  = 3;
        end else begin
            if (m_err < ET) m_err++;
            e.lat = 2;
        end
        e.ok   = (e.err == ERR_NONE);
        e.cur  = m_cur;
        e.hst  = m_hist;
        e.ecnt = 2'(m_err);
        e.alrt = m_alert;
        e.acc  = cyc;
        exp_q.push_back(e);
        @(negedge clk);
        bus.req_valid = 1'b0;
        g = 0;
        while (!bus.rsp_valid && g < 20) begin
            @(negedge clk);
            g++;
        end
        chk("rsp_seen", bus.rsp_valid, 1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int g;
        bus.req_valid  = 1'b0;
        bus.req_target = '0;
        legal_map      = 64'h2;
        model_reset();

        // rejections, counter clear on commit, no lock after two rejects
        do_reset();
        send(3'd3, 3'd3);
        chk("illegal_cur", cur_state, 0);
        send(3'd0, 3'd0);
        send(3'd1, 3'd1);
        chk("commit_cur",  cur_state, 1);
        chk("commit_hist0", hist[SW-1:0], 1);
        chk("cnt_clr",     err_cnt, 0);
        send(3'd2, 3'd1);
        send(3'd7, 3'd7);
        @(negedge clk);
        chk("no_lock",     locked, 0);
        chk("no_lock_rdy", bus.req_ready, 1);

        // lockout after three consecutive illegal requests
        do_reset();
        repeat (3) send(3'd2, 3'd2);
        @(negedge clk);
        chk("lock_locked", locked, 1);
        chk("lock_alert",  alert, 1);
        chk("lock_ecnt",   err_cnt, ET);
        n = 0;
        while (!bus.req_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("lock_len",    n, LC);
        chk("lock_off",    locked, 0);
        chk("lock_ecnt0",  err_cnt, 0);
        send(3'd1, 3'd1);
        chk("post_lock_cur",   cur_state, 1);
        chk("post_lock_alert", alert, 1);

        // reset while the request sits in CHECK
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_target = {3'd2, 3'd2};
        g = 0;
        while (!bus.req_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk("mid_accept", bus.req_ready, 1);
        @(negedge clk);
        rst_n = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        n = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.rsp_valid) n++;
        end
        chk("mid_no_rsp", n, 0);
        chk("mid_cur",    cur_state, 0);
        chk("mid_alert",  alert, 0);
        chk("mid_hist",   hist, 0);
        chk("mid_ecnt",   err_cnt, 0);

        // full chain into terminal state 3
        do_reset();
        legal_map = '1;
        legal_map[31:24] = '0;
        send(3'd1, 3'd1);
        send(3'd2, 3'd2);
        send(3'd3, 3'd3);
        chk("seq_hist", hist, 12'h053);
        chk("seq_cur",  cur_state, 3);
        send(3'd0, 3'd0);
        chk("term_err0", bus.rsp_err, ERR_ILLEGAL);
        send(3'd2, 3'd2);
        chk("term_err2", bus.rsp_err, ERR_ILLEGAL);
        chk("term_ecnt", err_cnt, 2);

        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lc_trans_guard.md
# lc_trans_guard

Parametrised life-cycle transition controller that sits between the transition command interface and the life-cycle state register. Each request carries a redundantly encoded target state and is checked for encoding integrity, validity and a configurable legality matrix before it is committed. All commits are recorded in a history buffer. Repeated rejected requests trigger a timed lockout and a sticky alert, closing the path by which sequences of unchecked transitions reach privileged states.

## Interface
- STATE_W, 3: width of one state encoding.
- NUM_REP, 2: redundant copies of the target carried per request.
- NUM_STATES, 8: number of encodable states; code NUM_STATES-1 is INVALID.
- RESET_STATE, 0: value of cur_state after reset (RAW).
- HIST_DEPTH, 4: committed-transition history entries.
- ERR_THRESH, 3: consecutive rejections that trigger lockout; must be ≥1.
- LOCK_CYCLES, 16: lockout duration in cycles; must be ≥1.
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  transition request.
- req_target  in  NUM_REP*STATE_W  redundant target copies; copy 0 is in the LSBs.
- req_ready  out  1  request accepted when high with req_valid.
- legal_map  in  NUM_STATES*NUM_STATES  static config; bit from*NUM_STATES+to set means the transition is legal.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_ok  out  1  transition committed; qualified by rsp_valid.
- rsp_err  out  3  error code; qualified by rsp_valid.
- cur_state  out  STATE_W  committed life-cycle state.
- hist  out  HIST_DEPTH*STATE_W  committed targets; entry 0 is the newest.
- err_cnt  out  $clog2(ERR_THRESH+1)  consecutive rejections.
- locked  out  1  lockout active.
- alert  out  1  sticky; set on any lockout entry.

## Operation
- The FSM has five states: IDLE, CHECK, COMMIT, RESP and LOCK.
- **IDLE:** req_ready=1. On req_valid, the block captures req_target and moves to CHECK.
- **CHECK:** evaluates the captured target (copy 0 is the target `t`) in priority order. The first failing check sets rsp_err:
  - 1 REDUN: the copies are not all equal.
  - 2 INVALID: t ≥ NUM_STATES-1.
  - 3 SELF: t == cur_state.
  - 4 ILLEGAL: the legal_map bit is 0.
  - 0: none of the above fail.
  - If rsp_err==0 the FSM moves to COMMIT. Otherwise err_cnt increments, saturating at ERR_THRESH, and the FSM moves to RESP.
- **COMMIT:** cur_state←t. The history shifts: hist[0]←t and the oldest entry is dropped. err_cnt←0. The FSM then moves to RESP.
- **RESP:** rsp_valid=1, with rsp_ok=(rsp_err==0). The next state is LOCK if err_cnt==ERR_THRESH, otherwise IDLE.
- **LOCK:** req_ready=0, locked=1 and alert←1. A down-counter loaded with LOCK_CYCLES-1 on entry runs to 0. At 0 the block clears err_cnt and returns to IDLE.
- rsp_ok, rsp_err and hist hold their values outside RESP. They are not cleared.
- A state whose legal_map row is all zero is terminal; every request from it returns ILLEGAL.
- alert clears only on reset.

## Timing
- Reset values:
  - FSM in IDLE.
  - cur_state=RESET_STATE.
  - hist all RESET_STATE.
  - err_cnt=0.
  - rsp_valid=0, rsp_ok=0, rsp_err=0.
  - locked=0, alert=0, lock counter 0.
  - req_ready=0 while rst_n is low.
- Latency, counted from the accepting edge k:
  - Rejected request: rsp_valid is high in cycle k+2.
  - Committed request: rsp_valid is high in cycle k+3.
  - cur_state and hist take their new value at the same edge that raises rsp_valid.
- req_ready is low from CHECK through RESP, so only one request is in flight. A req_valid held high through RESP is accepted on the first IDLE cycle after it.
- LOCK lasts exactly LOCK_CYCLES cycles. If req_valid is held high, it is accepted on the first cycle after LOCK.
- legal_map is sampled in CHECK only. A change to it mid-request does not affect a request already past CHECK.
- Reset mid-request: the request is dropped, no response is produced, and all registers return to their reset values.

## Structure
- A package lc_trans_guard_pkg holds:
  - the FSM enum;
  - the error-code localparams ERR_NONE, ERR_REDUN, ERR_INVALID, ERR_SELF, ERR_ILLEGAL;
  - a dec_lc_state_e enum covering RAW=0, TEST_UNLOCKED0=1, TEST_LOCKED0=2, RMA=3, INVALID=7 for benches.
- Sub-module lc_hist_buf: a parametrised HIST_DEPTH×STATE_W shift register with a push strobe and reset value RESET_STATE.

## Test plan
- **Legal commit:** legal_map permits 0→1; reset, then request {1,1}. Expect rsp_valid at k+3 with rsp_ok=1, rsp_err=0, cur_state=1, hist[0]=1.
- **Rejections:**
  - Request {3,3} with bit 0*8+3 clear gives rsp_err=4 at k+2 and cur_state stays 0.
  - Request {1,2} gives rsp_err=1.
  - Request {7,7} gives rsp_err=2.
  - Request {0,0} gives rsp_err=3.
- **Lockout:** three consecutive illegal requests lead to locked=1 and alert=1. req_ready stays 0 for exactly 16 cycles. Afterwards err_cnt=0 and a legal request commits; alert is still 1.
- **Counter reset:** two rejects, then one legal commit, gives err_cnt=0. Two further rejects do not lock.
- **Sequence 0→1→2→3 with all permitted:** hist={3,2,1,0} (newest first). Then every request from the terminal row 3 returns ILLEGAL.
- **Reset mid-request:** rst_n is low for one cycle while in CHECK. Expect no rsp_valid, cur_state=0 and alert=0.
